// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback stage: FSM encoding, destination
// select values, flag bit positions and the default STATUS file address.
package alu_writeback_pkg;

   typedef enum logic [1:0] {
      WB_IDLE    = 2'd0,
      WB_EXEC    = 2'd1,
      WB_WRITE_F = 2'd2,
      WB_DONE    = 2'd3
   } wb_state_e;

   localparam logic       WB_DEST_W = 1'b0;
   localparam logic       WB_DEST_F = 1'b1;

   localparam logic [4:0] WB_STATUS_ADDR = 5'h03;

   localparam int FLAG_Z  = 2;
   localparam int FLAG_DC = 1;
   localparam int FLAG_C  = 0;

endpackage

// File: rtl/alu_writeback_status_merge.sv
// Combinational next-flag select: a STATUS-address file write overrides the
// ALU flags, which in turn override holding the current flags.
module wb_status_merge #(
   parameter int STATUS_WIDTH = 3
) (
   input  logic [STATUS_WIDTH-1:0] holdFlags,
   input  logic [STATUS_WIDTH-1:0] aluFlags,
   input  logic                    aluFlagsEn,
   input  logic [STATUS_WIDTH-1:0] ovrFlags,
   input  logic                    ovrEn,
   output logic [STATUS_WIDTH-1:0] nextFlags
);

   always_comb begin
      nextFlags = holdFlags;
      if (ovrEn) begin
         nextFlags = ovrFlags;
      end else if (aluFlagsEn) begin
         nextFlags = aluFlags;
      end
   end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits a captured ALU result to W or to the register
// file, owns W and the {Z,DC,C} flags, and raises the DECFSZ/INCFSZ skip pulse.
// Optional build macro WB_BYPASS_EN forwards pending W/flags during EXEC.
module alu_writeback
   import alu_writeback_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    STATUS_WIDTH = 3,
   parameter int                    ADDR_WIDTH   = 5,
   parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR  = ADDR_WIDTH'(WB_STATUS_ADDR)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wbStart,
   input  logic                    wbDest,
   input  logic [ADDR_WIDTH-1:0]   fAddrIn,
   input  logic [DATA_WIDTH-1:0]   aluResultIn,
   input  logic [STATUS_WIDTH-1:0] aluStatusIn,
   input  logic                    statusWrEn,
   input  logic                    skipTest,
   input  logic                    fileWrAck,
   output logic [DATA_WIDTH-1:0]   wOut,
   output logic [STATUS_WIDTH-1:0] statusOut,
   output logic                    fileWrEn,
   output logic [ADDR_WIDTH-1:0]   fileWrAddr,
   output logic [DATA_WIDTH-1:0]   fileWrData,
   output logic                    skipOut,
   output logic                    wbBusy,
   output logic                    wbDone
);

   wb_state_e               state_q, state_d;
   logic                    capDest_q;
   logic [ADDR_WIDTH-1:0]   capAddr_q;
   logic [DATA_WIDTH-1:0]   capResult_q;
   logic [STATUS_WIDTH-1:0] capFlags_q;
   logic                    capFlagsEn_q;
   logic                    capSkip_q;

   logic [DATA_WIDTH-1:0]   w_q, w_d;
   logic [STATUS_WIDTH-1:0] status_q, status_d;
   logic [STATUS_WIDTH-1:0] mergedFlags;
   logic                    commit;
   logic                    statusOvr;

   // Capture registers load only on an accepted request; they need no reset
   // because every output derived from them is gated by the FSM state.
   always_ff @(posedge clk) begin
      if (state_q == WB_IDLE && wbStart) begin
         capDest_q    <= wbDest;
         capAddr_q    <= fAddrIn;
         capResult_q  <= aluResultIn;
         capFlags_q   <= aluStatusIn;
         capFlagsEn_q <= statusWrEn;
         capSkip_q    <= skipTest;
      end
   end

   assign statusOvr = (capDest_q == WB_DEST_F) && (capAddr_q == STATUS_ADDR);

   wb_status_merge #(
      .STATUS_WIDTH(STATUS_WIDTH)
   ) u_status_merge (
      .holdFlags (status_q),
      .aluFlags  (capFlags_q),
      .aluFlagsEn(capFlagsEn_q),
      .ovrFlags  (capResult_q[STATUS_WIDTH-1:0]),
      .ovrEn     (statusOvr),
      .nextFlags (mergedFlags)
   );

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      commit  = 1'b0;
      unique case (state_q)
         WB_IDLE: begin
            if (wbStart) state_d = WB_EXEC;
         end
         WB_EXEC: begin
            if (capDest_q == WB_DEST_W) begin
               w_d     = capResult_q;
               commit  = 1'b1;
               state_d = WB_DONE;
            end else begin
               state_d = WB_WRITE_F;
            end
         end
         WB_WRITE_F: begin
            if (fileWrAck) begin
               commit  = 1'b1;
               state_d = WB_DONE;
            end
         end
         WB_DONE: begin
            state_d = WB_IDLE;
         end
         default: state_d = WB_IDLE;
      endcase
      status_d = commit ? mergedFlags : status_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= WB_IDLE;
         w_q      <= '0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         w_q      <= w_d;
         status_q <= status_d;
      end
   end

   assign fileWrEn   = (state_q == WB_WRITE_F);
   assign fileWrAddr = fileWrEn ? capAddr_q : '0;
   assign fileWrData = fileWrEn ? capResult_q : '0;
   assign wbDone     = (state_q == WB_DONE);
   assign skipOut    = wbDone && capSkip_q && (capResult_q == '0);
   assign wbBusy     = (state_q != WB_IDLE);

`ifdef WB_BYPASS_EN
   // W-destination commit is known during EXEC, so forward it a cycle early.
   assign wOut      = (state_q == WB_EXEC && capDest_q == WB_DEST_W) ? capResult_q : w_q;
   assign statusOut = (state_q == WB_EXEC && capDest_q == WB_DEST_W) ? mergedFlags : status_q;
`else
   assign wOut      = w_q;
   assign statusOut = status_q;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized
// transactions compared against a transaction-level model of W and STATUS.
module tb_alu_writeback;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wbStart;
   logic       wbDest;
   logic [4:0] fAddrIn;
   logic [7:0] aluResultIn;
   logic [2:0] aluStatusIn;
   logic       statusWrEn;
   logic       skipTest;
   logic       fileWrAck;
   logic [7:0] wOut;
   logic [2:0] statusOut;
   logic       fileWrEn;
   logic [4:0] fileWrAddr;
   logic [7:0] fileWrData;
   logic       skipOut;
   logic       wbBusy;
   logic       wbDone;

   int         checks = 0;
   int         errors = 0;

   // Architectural model of the visible registers
   logic [7:0] w_m  = 8'h00;
   logic [2:0] st_m = 3'b000;

   alu_writeback dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wbStart    (wbStart),
      .wbDest     (wbDest),
      .fAddrIn    (fAddrIn),
      .aluResultIn(aluResultIn),
      .aluStatusIn(aluStatusIn),
      .statusWrEn (statusWrEn),
      .skipTest   (skipTest),
      .fileWrAck  (fileWrAck),
      .wOut       (wOut),
      .statusOut  (statusOut),
      .fileWrEn   (fileWrEn),
      .fileWrAddr (fileWrAddr),
      .fileWrData (fileWrData),
      .skipOut    (skipOut),
      .wbBusy     (wbBusy),
      .wbDone     (wbDone)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic scramble;
      wbDest      = 1'($urandom);
      fAddrIn     = 5'($urandom);
      aluResultIn = 8'($urandom);
      aluStatusIn = 3'($urandom);
      statusWrEn  = 1'($urandom);
      skipTest    = 1'($urandom);
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_w"},     wOut, 0);
      chk({pfx, "_st"},    statusOut, 0);
      chk({pfx, "_fwe"},   fileWrEn, 0);
      chk({pfx, "_faddr"}, fileWrAddr, 0);
      chk({pfx, "_fdata"}, fileWrData, 0);
      chk({pfx, "_skip"},  skipOut, 0);
      chk({pfx, "_done"},  wbDone, 0);
      chk({pfx, "_busy"},  wbBusy, 0);
   endtask

   // One complete transaction; expected values come from the flag/skip rules.
   task automatic txn(input logic dest, input logic [4:0] addr, input logic [7:0] res,
                      input logic [2:0] fl, input logic swe, input logic skp,
                      input int dly, input logic poke);
      logic [7:0] w_old;
      logic [2:0] st_exp;
      logic       skip_exp;
      w_old    = w_m;
      st_exp   = (dest && addr == 5'h03) ? res[2:0] : (swe ? fl : st_m);
      skip_exp = skp && (res == 8'h00);

      wbStart = 1'b1; wbDest = dest; fAddrIn = addr; aluResultIn = res;
      aluStatusIn = fl; statusWrEn = swe; skipTest = skp;
      tick;
      wbStart = 1'b0;
      scramble;
      chk("exec_busy", wbBusy, 1);
      chk("exec_done", wbDone, 0);
      chk("exec_fwe", fileWrEn, 0);
`ifdef WB_BYPASS_EN
      chk("exec_w", wOut, dest ? w_old : res);
      chk("exec_st", statusOut, dest ? st_m : st_exp);
`else
      chk("exec_w", wOut, w_old);
      chk("exec_st", statusOut, st_m);
`endif
      tick;
      if (!dest) begin
         chk("wdone_done", wbDone, 1);
         chk("wdone_w", wOut, res);
         chk("wdone_st", statusOut, st_exp);
         chk("wdone_skip", skipOut, skip_exp);
         chk("wdone_fwe", fileWrEn, 0);
         w_m = res;
      end else begin
         chk("wf_fwe", fileWrEn, 1);
         chk("wf_addr", fileWrAddr, addr);
         chk("wf_data", fileWrData, res);
         for (int i = 0; i < dly; i++) begin
            if (poke && i == 0) wbStart = 1'b1;
            tick;
            wbStart = 1'b0;
            chk("wf_hold_fwe", fileWrEn, 1);
            chk("wf_hold_addr", fileWrAddr, addr);
            chk("wf_hold_data", fileWrData, res);
            chk("wf_hold_done", wbDone, 0);
         end
         fileWrAck = 1'b1;
         tick;
         fileWrAck = 1'b0;
         chk("fdone_fwe", fileWrEn, 0);
         chk("fdone_done", wbDone, 1);
         chk("fdone_st", statusOut, st_exp);
         chk("fdone_w", wOut, w_old);
         chk("fdone_skip", skipOut, skip_exp);
      end
      st_m = st_exp;
      tick;
      chk("idle_done", wbDone, 0);
      chk("idle_busy", wbBusy, 0);
      chk("idle_skip", skipOut, 0);
   endtask

   initial begin
      rst_n = 1'b0; wbStart = 1'b0; fileWrAck = 1'b0;
      scramble;
      tick; tick;
      chk_reset_outputs("rst");
      rst_n = 1'b1;
      tick;
      chk("post_rst_busy", wbBusy, 0);

      // Directed scenarios
      txn(1'b0, 5'h00, 8'h5A, 3'b001, 1'b1, 1'b0, 0, 1'b0);
      txn(1'b1, 5'h10, 8'hC3, 3'b010, 1'b0, 1'b0, 3, 1'b0);
      txn(1'b1, 5'h03, 8'h05, 3'b000, 1'b1, 1'b0, 1, 1'b0);
      txn(1'b0, 5'h00, 8'h00, 3'b100, 1'b1, 1'b1, 0, 1'b0);
      txn(1'b0, 5'h00, 8'h01, 3'b000, 1'b1, 1'b1, 0, 1'b0);
      txn(1'b1, 5'h07, 8'h00, 3'b110, 1'b1, 1'b1, 2, 1'b0);
      txn(1'b1, 5'h12, 8'h9E, 3'b011, 1'b1, 1'b0, 3, 1'b1);
      txn(1'b0, 5'h00, 8'h33, 3'b111, 1'b1, 1'b0, 0, 1'b0);
      txn(1'b0, 5'h00, 8'h44, 3'b000, 1'b0, 1'b0, 0, 1'b0);
      chk("swe0_hold", statusOut, 3'b111);

      // Reset while waiting for the file ack abandons the transaction
      wbStart = 1'b1; wbDest = 1'b1; fAddrIn = 5'h03; aluResultIn = 8'h02;
      aluStatusIn = 3'b001; statusWrEn = 1'b1; skipTest = 1'b1;
      tick;
      wbStart = 1'b0;
      tick;
      chk("rstmid_fwe_pre", fileWrEn, 1);
      rst_n = 1'b0;
      fileWrAck = 1'b1;
      tick;
      fileWrAck = 1'b0;
      chk_reset_outputs("rstmid");
      rst_n = 1'b1;
      w_m = 8'h00; st_m = 3'b000;
      tick;
      chk("rstmid_idle", wbBusy, 0);

      // Randomized transactions
      for (int n = 0; n < 60; n++) begin
         logic [4:0] a;
         logic [7:0] r;
         a = ($urandom_range(0, 3) == 0) ? 5'h03 : 5'($urandom);
         r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         txn(1'($urandom), a, r, 3'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 4), 1'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            tick;
            chk("gap_busy", wbBusy, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
